// File: rtl/sort_pkg.sv
// ============================================================================
// Module : sort_pkg
// Brief  : Shared types, constants and helpers for the sorter unload path.
//          Optional feature macro used by sort_vec_unload: SORT_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_pkg;

  // Default element width; elem_t is the element type at that width.
  localparam int ELEM_W = 4;
  typedef logic [ELEM_W-1:0] elem_t;

  // Unload controller states.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } unload_st_e;

  // Index width for an n-element vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_order_chk.sv
// ============================================================================
// Module : sort_order_chk
// Brief  : Combinational order check of a packed vector. ok=1 when every
//          adjacent pair satisfies the ASCEND ordering (unsigned compare).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_order_chk #(
  parameter int DATA_W = 4,
  parameter int DATA_N = 4,
  parameter bit ASCEND = 1'b1
) (
  input  logic [DATA_N-1:0][DATA_W-1:0] vec,
  output logic                          ok
);

  // Any adjacent pair out of order clears ok; equal neighbours are allowed.
  always_comb begin
    ok = 1'b1;
    for (int i = 0; i < DATA_N - 1; i++) begin
      if (ASCEND) begin
        if (vec[i] > vec[i+1]) ok = 1'b0;
      end else begin
        if (vec[i] < vec[i+1]) ok = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sort_vec_unload.sv
// ============================================================================
// Module : sort_vec_unload
// Brief  : Serialises sorted DATA_N x DATA_W vectors into an element stream.
//          One active buffer plus one shadow buffer give bubble-free
//          back-to-back draining. Optional order checker under SORT_CHECK_EN
//          adds the sticky err_unsorted output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_vec_unload
  import sort_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int DATA_N = 4,
  parameter  bit ASCEND = 1'b1,
  localparam int IDX_W  = idx_w(DATA_N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_N-1:0][DATA_W-1:0] data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy
`ifdef SORT_CHECK_EN
  ,
  output logic                          err_unsorted
`endif
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_N - 1);

  typedef logic [DATA_N-1:0][DATA_W-1:0] vec_t;

  unload_st_e       r_state;
  unload_st_e       w_next_state;
  vec_t             r_active;
  vec_t             r_shadow;
  logic             r_shadow_full;
  logic             r_rdy_en;
  logic [IDX_W-1:0] r_idx;

  logic w_in_acc;
  logic w_out_acc;
  logic w_at_last;

  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = out_valid & out_ready;
  assign w_at_last = (r_idx == C_LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: leave DRAIN only on a last beat with nothing to refill from.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_in_acc) w_next_state = S_DRAIN;
      S_DRAIN: if (w_out_acc && w_at_last && !r_shadow_full && !w_in_acc)
                 w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs: element select from the active buffer, ready gated until the
  // first clock after reset so no vector is taken while reset is settling.
  always_comb begin
    out_valid = (r_state == S_DRAIN);
    out_data  = r_active[r_idx];
    out_idx   = r_idx;
    out_last  = (r_state == S_DRAIN) & w_at_last;
    busy      = (r_state == S_DRAIN) | r_shadow_full;
    in_ready  = r_rdy_en & ~r_shadow_full;
  end

  // Buffers and index: load/advance/reload. A shadow write can never
  // coincide with a shadow move, since in_ready is low while it is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en      <= 1'b0;
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_idx         <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (r_state == S_IDLE) begin
        if (w_in_acc) begin
          r_active <= data_in;
          r_idx    <= '0;
        end
      end else begin
        if (w_out_acc && !w_at_last) begin
          r_idx <= r_idx + IDX_W'(1);
        end else if (w_out_acc) begin
          if (r_shadow_full) begin
            r_active      <= r_shadow;
            r_idx         <= '0;
            r_shadow_full <= 1'b0;
          end else if (w_in_acc) begin
            r_active <= data_in;
            r_idx    <= '0;
          end
        end
        if (w_in_acc && !(w_out_acc && w_at_last)) begin
          r_shadow      <= data_in;
          r_shadow_full <= 1'b1;
        end
      end
    end
  end

`ifdef SORT_CHECK_EN
  logic w_order_ok;
  logic r_err;

  sort_order_chk #(
    .DATA_W (DATA_W),
    .DATA_N (DATA_N),
    .ASCEND (ASCEND)
  ) u_order_chk (
    .vec (data_in),
    .ok  (w_order_ok)
  );

  // Sticky error: any accepted out-of-order vector latches it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_err <= 1'b0;
    else if (w_in_acc && !w_order_ok) r_err <= 1'b1;
  end

  assign err_unsorted = r_err;
`endif

endmodule

`default_nettype wire
